// File: rtl/ofs_fim_pcie_ss_rx_cpld_req_arb.sv
// Packet-level weighted round-robin merge of the RX CplD and RX request AXI-S streams
// onto one registered AXI-S output; the owner is held for a whole packet.
module ofs_fim_pcie_ss_rx_cpld_req_arb #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned USER_W      = 10,
  parameter int unsigned CPLD_WEIGHT = 4,
  parameter int unsigned REQ_WEIGHT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      cpld_tvalid,
  output logic                      cpld_tready,
  input  logic [DATA_WIDTH-1:0]     cpld_tdata,
  input  logic [DATA_WIDTH/8-1:0]   cpld_tkeep,
  input  logic                      cpld_tlast,
  input  logic [USER_W-1:0]         cpld_tuser,

  input  logic                      req_tvalid,
  output logic                      req_tready,
  input  logic [DATA_WIDTH-1:0]     req_tdata,
  input  logic [DATA_WIDTH/8-1:0]   req_tkeep,
  input  logic                      req_tlast,
  input  logic [USER_W-1:0]         req_tuser,

  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic [DATA_WIDTH-1:0]     out_tdata,
  output logic [DATA_WIDTH/8-1:0]   out_tkeep,
  output logic                      out_tlast,
  output logic [USER_W-1:0]         out_tuser,
  output logic                      out_src,

  output logic [31:0]               cpld_pkt_cnt,
  output logic [31:0]               req_pkt_cnt
);

  localparam int unsigned RND_W = 8;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} lock_state_e;

  lock_state_e        state, state_nxt;
  logic               owner, owner_nxt;
  logic               prio, prio_nxt;
  logic [RND_W-1:0]   round_cnt, round_nxt;

  logic               adv_c;
  logic               grant_c;
  logic               sel_c;
  logic               sel_valid_c;
  logic               sel_last_c;
  logic               xfer_c;
  logic [RND_W-1:0]   wt_m1_c;

  // Grant selection: locked owner first, else priority side, else the other side
  always_comb begin
    adv_c   = !out_tvalid || out_tready;
    sel_c   = prio;
    grant_c = 1'b0;
    if (state == ST_LOCKED) begin
      sel_c   = owner;
      grant_c = 1'b1;
    end else if (prio ? req_tvalid : cpld_tvalid) begin
      sel_c   = prio;
      grant_c = 1'b1;
    end else if (prio ? cpld_tvalid : req_tvalid) begin
      sel_c   = !prio;
      grant_c = 1'b1;
    end
    sel_valid_c = sel_c ? req_tvalid : cpld_tvalid;
    sel_last_c  = sel_c ? req_tlast  : cpld_tlast;
    xfer_c      = grant_c && sel_valid_c && adv_c;
    wt_m1_c     = prio ? RND_W'(REQ_WEIGHT - 1) : RND_W'(CPLD_WEIGHT - 1);
  end

  assign cpld_tready = rst_n && grant_c && !sel_c && adv_c;
  assign req_tready  = rst_n && grant_c &&  sel_c && adv_c;

  // Lock FSM and WRR bookkeeping
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    round_nxt = round_cnt;
    case (state)
      ST_UNLOCKED: if (xfer_c && !sel_last_c) begin
        state_nxt = ST_LOCKED;
        owner_nxt = sel_c;
      end
      ST_LOCKED: if (xfer_c && sel_last_c) state_nxt = ST_UNLOCKED;
      default: state_nxt = ST_UNLOCKED;
    endcase
    // Only completions from the priority side consume its weight
    if (xfer_c && sel_last_c && (sel_c == prio)) begin
      if (round_cnt == wt_m1_c) begin
        prio_nxt  = !prio;
        round_nxt = '0;
      end else begin
        round_nxt = round_cnt + RND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_UNLOCKED;
      owner     <= 1'b0;
      prio      <= 1'b0;
      round_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      prio      <= prio_nxt;
      round_cnt <= round_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_tvalid <= 1'b0;
    end else if (xfer_c) begin
      out_tvalid <= 1'b1;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

  // Payload needs no reset: it is only meaningful while out_tvalid is set
  always_ff @(posedge clk) begin
    if (xfer_c) begin
      out_tdata <= sel_c ? req_tdata : cpld_tdata;
      out_tkeep <= sel_c ? req_tkeep : cpld_tkeep;
      out_tlast <= sel_last_c;
      out_tuser <= sel_c ? req_tuser : cpld_tuser;
      out_src   <= sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpld_pkt_cnt <= '0;
      req_pkt_cnt  <= '0;
    end else if (xfer_c && sel_last_c) begin
      if (!sel_c && (cpld_pkt_cnt != 32'hFFFF_FFFF)) cpld_pkt_cnt <= cpld_pkt_cnt + 32'd1;
      if ( sel_c && (req_pkt_cnt  != 32'hFFFF_FFFF)) req_pkt_cnt  <= req_pkt_cnt  + 32'd1;
    end
  end

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_cpld_req_arb.sv
// Directed bench for the CplD/request WRR packet arbiter: vector table plus multi-cycle sequences.
module tb_ofs_fim_pcie_ss_rx_cpld_req_arb;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cpld_tvalid, cpld_tready, cpld_tlast;
  logic [DW-1:0]  cpld_tdata;
  logic [KW-1:0]  cpld_tkeep;
  logic [UW-1:0]  cpld_tuser;
  logic           req_tvalid, req_tready, req_tlast;
  logic [DW-1:0]  req_tdata;
  logic [KW-1:0]  req_tkeep;
  logic [UW-1:0]  req_tuser;
  logic           out_tvalid, out_tready, out_tlast, out_src;
  logic [DW-1:0]  out_tdata;
  logic [KW-1:0]  out_tkeep;
  logic [UW-1:0]  out_tuser;
  logic [31:0]    cpld_pkt_cnt, req_pkt_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ofs_fim_pcie_ss_rx_cpld_req_arb dut (
    .clk(clk), .rst_n(rst_n),
    .cpld_tvalid(cpld_tvalid), .cpld_tready(cpld_tready), .cpld_tdata(cpld_tdata),
    .cpld_tkeep(cpld_tkeep), .cpld_tlast(cpld_tlast), .cpld_tuser(cpld_tuser),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .req_tkeep(req_tkeep), .req_tlast(req_tlast), .req_tuser(req_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .out_tkeep(out_tkeep), .out_tlast(out_tlast), .out_tuser(out_tuser), .out_src(out_src),
    .cpld_pkt_cnt(cpld_pkt_cnt), .req_pkt_cnt(req_pkt_cnt)
  );

  typedef struct {
    logic cv, cl, rv, rl, ordy;
    logic e_cr, e_rr, e_ov, e_src;
    int   e_idx;
  } vec_t;

  function automatic vec_t mk(logic cv, logic cl, logic rv, logic rl, logic ordy,
                              logic e_cr, logic e_rr, logic e_ov, logic e_src, int e_idx);
    vec_t v;
    v.cv = cv; v.cl = cl; v.rv = rv; v.rl = rl; v.ordy = ordy;
    v.e_cr = e_cr; v.e_rr = e_rr; v.e_ov = e_ov; v.e_src = e_src; v.e_idx = e_idx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic cv, input logic cl, input logic [15:0] cd,
                     input logic rv, input logic rl, input logic [15:0] rd, input logic ordy);
    cpld_tvalid = cv; cpld_tlast = cl; cpld_tdata = DW'(cd);
    req_tvalid  = rv; req_tlast  = rl; req_tdata  = DW'(rd);
    out_tready  = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_cpld_cnt", 64'(cpld_pkt_cnt), 64'd0);
    chk("rst_req_cnt", 64'(req_pkt_cnt), 64'd0);
  endtask

  vec_t vecs[14];

  initial begin
    cpld_tkeep = '1; req_tkeep = '1;
    cpld_tuser = 10'h155; req_tuser = 10'h2AA;

    // cv cl rv rl ordy | cr rr ov src idx
    vecs[0]  = mk(0,0,0,0,1, 0,0,0,0, 0);
    vecs[1]  = mk(1,1,1,1,1, 1,0,1,0, 1);
    vecs[2]  = mk(1,1,1,1,1, 1,0,1,0, 2);
    vecs[3]  = mk(1,1,1,1,1, 1,0,1,0, 3);
    vecs[4]  = mk(1,1,1,1,1, 1,0,1,0, 4);
    vecs[5]  = mk(1,1,1,1,1, 0,1,1,1, 5);
    vecs[6]  = mk(1,1,1,1,1, 1,0,1,0, 6);
    vecs[7]  = mk(0,0,1,1,1, 0,1,1,1, 7);
    vecs[8]  = mk(1,1,1,1,1, 1,0,1,0, 8);
    vecs[9]  = mk(1,1,0,0,0, 0,0,1,0, 8);
    vecs[10] = mk(1,1,0,0,1, 1,0,1,0, 10);
    vecs[11] = mk(1,1,1,1,1, 1,0,1,0, 11);
    vecs[12] = mk(1,1,1,1,1, 0,1,1,1, 12);
    vecs[13] = mk(0,0,0,0,1, 0,0,0,0, 0);

    do_reset();

    for (int i = 0; i < 14; i++) begin
      drv(vecs[i].cv, vecs[i].cl, 16'(16'hC000 + i), vecs[i].rv, vecs[i].rl, 16'(16'hA000 + i), vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_cpld_tready", i), 64'(cpld_tready), 64'(vecs[i].e_cr));
      chk($sformatf("v%0d_req_tready", i), 64'(req_tready), 64'(vecs[i].e_rr));
      tick();
      chk($sformatf("v%0d_out_tvalid", i), 64'(out_tvalid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_out_src", i), 64'(out_src), 64'(vecs[i].e_src));
        chk($sformatf("v%0d_out_tdata", i), out_tdata[63:0],
            64'((vecs[i].e_src ? 16'hA000 : 16'hC000) + 16'(vecs[i].e_idx)));
        chk($sformatf("v%0d_out_tuser", i), 64'(out_tuser), 64'(vecs[i].e_src ? 10'h2AA : 10'h155));
        chk($sformatf("v%0d_out_tlast", i), 64'(out_tlast), 64'd1);
      end
    end
    chk("tbl_cpld_cnt", 64'(cpld_pkt_cnt), 64'd8);
    chk("tbl_req_cnt", 64'(req_pkt_cnt), 64'd3);

    // 3-beat CplD packet with a stalled beat; req must wait for the tlast beat
    drv(1, 0, 16'h0B01, 0, 0, 16'h0, 1); tick();
    chk("lk_b1_src", 64'(out_src), 64'd0);
    drv(1, 0, 16'h0B02, 1, 1, 16'h0E01, 1); #1;
    chk("lk_b2_req_tready", 64'(req_tready), 64'd0);
    chk("lk_b2_cpld_tready", 64'(cpld_tready), 64'd1);
    tick();
    drv(0, 0, 16'h0B03, 1, 1, 16'h0E01, 1); #1;
    chk("lk_stall_req_tready", 64'(req_tready), 64'd0);
    chk("lk_stall_cpld_tready", 64'(cpld_tready), 64'd1);
    tick();
    chk("lk_stall_out_tvalid", 64'(out_tvalid), 64'd0);
    drv(1, 1, 16'h0B03, 1, 1, 16'h0E01, 1); #1;
    chk("lk_b3_req_tready", 64'(req_tready), 64'd0);
    tick();
    chk("lk_b3_out_tdata", out_tdata[63:0], 64'h0B03);
    chk("lk_b3_out_tlast", 64'(out_tlast), 64'd1);
    drv(0, 0, 16'h0, 1, 1, 16'h0E01, 1); #1;
    chk("lk_req_tready", 64'(req_tready), 64'd1);
    tick();
    chk("lk_req_out_src", 64'(out_src), 64'd1);
    chk("lk_req_out_tdata", out_tdata[63:0], 64'h0E01);

    // Ten request-only packets, then CplD still wins the next contested grant
    for (int i = 0; i < 10; i++) begin
      drv(0, 0, 16'h0, 1, 1, 16'(16'h0D00 + i), 1); tick();
      chk($sformatf("ro%0d_out", i), {out_tdata[15:0], 15'h0, out_src}, {16'(16'h0D00 + i), 15'h0, 1'b1});
    end
    chk("ro_req_cnt", 64'(req_pkt_cnt), 64'd14);
    drv(1, 1, 16'h0C77, 1, 1, 16'h0D77, 1); #1;
    chk("ro_cpld_wins_cr", 64'(cpld_tready), 64'd1);
    chk("ro_cpld_wins_rr", 64'(req_tready), 64'd0);
    tick();
    chk("ro_cpld_wins_src", 64'(out_src), 64'd0);
    chk("ro_cpld_cnt", 64'(cpld_pkt_cnt), 64'd10);

    // Output backpressure: payload stable, both inputs stalled, no loss or duplicate
    do_reset();
    drv(1, 1, 16'h0100, 0, 0, 16'h0, 1); tick();
    chk("bp_first", out_tdata[63:0], 64'h0100);
    for (int i = 0; i < 5; i++) begin
      drv(1, 1, 16'h0101, 1, 1, 16'h0F00, 0); #1;
      chk($sformatf("bp%0d_cpld_tready", i), 64'(cpld_tready), 64'd0);
      chk($sformatf("bp%0d_req_tready", i), 64'(req_tready), 64'd0);
      tick();
      chk($sformatf("bp%0d_hold", i), {out_tdata[15:0], 15'h0, out_tvalid}, {16'h0100, 15'h0, 1'b1});
    end
    drv(1, 1, 16'h0101, 0, 0, 16'h0, 1); tick();
    chk("bp_resume1", out_tdata[63:0], 64'h0101);
    drv(1, 1, 16'h0102, 0, 0, 16'h0, 1); tick();
    chk("bp_resume2", out_tdata[63:0], 64'h0102);
    chk("bp_cnt", 64'(cpld_pkt_cnt), 64'd3);

    // Reset during beat 2 of a 4-beat packet
    do_reset();
    drv(1, 1, 16'h0200, 0, 0, 16'h0, 1); tick();
    drv(1, 0, 16'h0201, 0, 0, 16'h0, 1); tick();
    drv(1, 0, 16'h0202, 0, 0, 16'h0, 1);
    rst_n = 1'b0; #1;
    chk("mr_cpld_tready_in_rst", 64'(cpld_tready), 64'd0);
    tick();
    chk("mr_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("mr_cpld_cnt", 64'(cpld_pkt_cnt), 64'd0);
    rst_n = 1'b1;
    drv(0, 0, 16'h0, 1, 1, 16'h0E10, 1); #1;
    chk("mr_unlocked", 64'(req_tready), 64'd1);
    tick();
    drv(1, 1, 16'h0203, 1, 1, 16'h0E11, 1); #1;
    chk("mr_prio_cpld", {63'h0, cpld_tready}, 64'd1);
    tick();

    // Counter saturation from a forced preload
    do_reset();
    force dut.cpld_pkt_cnt = 32'hFFFF_FFFE;
    tick();
    release dut.cpld_pkt_cnt;
    drv(1, 1, 16'h0300, 0, 0, 16'h0, 1); tick();
    chk("sat_first", 64'(cpld_pkt_cnt), 64'hFFFF_FFFF);
    drv(1, 1, 16'h0301, 0, 0, 16'h0, 1); tick();
    drv(1, 1, 16'h0302, 0, 0, 16'h0, 1); tick();
    chk("sat_hold", 64'(cpld_pkt_cnt), 64'hFFFF_FFFF);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 1); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
